// File: rtl/comparator_stream_extremum.sv
// comparator_stream_extremum
//   Streaming extremum finder for the output-layer decision path. One signed
//   membrane value is accepted per beat; after NUM_CLASSES accepted values the
//   index and value of the minimum (loser, mode 0) or maximum (winner, mode 1)
//   are presented with a one-cycle result_valid_o pulse.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   start_i, mode_i       frame start pulse; mode sampled with start_i
//   valid_i, variable_i   sample stream; class index = arrival order
//   ready_o, busy_o       high only while a frame is being accumulated
//   result_valid_o        one-cycle pulse when the result registers update
//   result_index_o        selected class index (held until the next result)
//   result_variable_o     selected class value (held until the next result)
module comparator_stream_extremum #(
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
  parameter int NUM_CLASSES            = 10,  // 2..256
  parameter int INDEX_WIDTH            = 4    // 2**INDEX_WIDTH >= NUM_CLASSES
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start_i,
  input  logic                                     mode_i,
  input  logic                                     valid_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable_i,
  output logic                                     ready_o,
  output logic                                     busy_o,
  output logic                                     result_valid_o,
  output logic        [INDEX_WIDTH-1:0]            result_index_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] result_variable_o
);

  // One extra bit so the count can reach NUM_CLASSES without wrapping.
  localparam int CNT_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                                   state, state_nxt;
  logic        [CNT_W-1:0]                  count;
  logic                                     mode_q;
  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] best_value;
  logic        [INDEX_WIDTH-1:0]            best_index;

  logic                                     accept, last, better, take;
  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] cand_value;
  logic        [INDEX_WIDTH-1:0]            cand_index;

  // start_i wins over a coincident sample, which is simply dropped.
  assign accept = (state == S_ACCUM) && valid_i && !start_i;
  assign last   = accept && (count == CNT_W'(NUM_CLASSES - 1));

  // Strict comparison keeps the earliest index on ties.
  assign better = mode_q ? (variable_i > best_value) : (variable_i < best_value);
  assign take   = (count == '0) || better;

  assign cand_value = take ? variable_i : best_value;
  assign cand_index = take ? INDEX_WIDTH'(count) : best_index;

  assign ready_o        = (state == S_ACCUM);
  assign busy_o         = (state == S_ACCUM);
  assign result_valid_o = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_i) state_nxt = S_ACCUM;
      S_ACCUM: if (!start_i && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start_i ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      count             <= '0;
      mode_q            <= 1'b0;
      best_value        <= '0;
      best_index        <= '0;
      result_index_o    <= '0;
      result_variable_o <= '0;
    end else begin
      state <= state_nxt;
      if (start_i) begin
        // Valid from every state: IDLE/DONE open a frame, ACCUM aborts and restarts.
        mode_q <= mode_i;
        count  <= '0;
      end else if (accept) begin
        best_value <= cand_value;
        best_index <= cand_index;
        count      <= count + 1'b1;
        if (last) begin
          result_index_o    <= cand_index;
          result_variable_o <= cand_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_comparator_stream_extremum.sv
module tb_comparator_stream_extremum;
  localparam int W  = 16;
  localparam int N  = 5;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start_i = 1'b0;
  logic                mode_i = 1'b0;
  logic                valid_i = 1'b0;
  logic signed [W-1:0] variable_i = '0;
  logic                ready_o, busy_o, result_valid_o;
  logic [IW-1:0]       result_index_o;
  logic signed [W-1:0] result_variable_o;

  comparator_stream_extremum #(
    .BIT_WIDTH_BIG_MEMBRANE(W), .NUM_CLASSES(N), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .mode_i(mode_i),
    .valid_i(valid_i), .variable_i(variable_i), .ready_o(ready_o),
    .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_index_o(result_index_o), .result_variable_o(result_variable_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, pulses = 0, exp_pulses = 0, pulse_cyc = 0;
  int exp_idx = 0, exp_val = 0;
  int samp[N];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (result_valid_o) pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: extreme value of the frame, then the first position holding it.
  task automatic ref_model(input logic m, output int idx, output int val);
    val = samp[0];
    foreach (samp[i]) if (m ? (samp[i] > val) : (samp[i] < val)) val = samp[i];
    idx = -1;
    foreach (samp[i]) if (idx < 0 && samp[i] == val) idx = i;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, int'(ready_o), 0);
    chk({tag, "_busy"},  int'(busy_o), 0);
    chk({tag, "_rv"},    int'(result_valid_o), 0);
    chk({tag, "_idx"},   int'(result_index_o), 0);
    chk({tag, "_val"},   int'(result_variable_o), 0);
  endtask

  // Called at a negedge; asserts start_i there. abort_after>=0 stops after that
  // many samples and returns at a negedge still inside the frame.
  task automatic run_frame(input logic m, input int gap_max, input int abort_after);
    int nsend, ridx, rval;
    start_i = 1'b1;
    mode_i  = m;
    nsend = (abort_after >= 0) ? abort_after : N;
    for (int i = 0; i < nsend; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk);
        start_i = 1'b0; valid_i = 1'b0;
        variable_i = W'($urandom); mode_i = 1'($urandom);
        chk("gap_busy", int'(busy_o), 1);
        chk("gap_rv", int'(result_valid_o), 0);
      end
      @(negedge clk);
      start_i = 1'b0; valid_i = 1'b1;
      variable_i = W'(samp[i]); mode_i = 1'($urandom);
      chk("ready", int'(ready_o), 1);
      chk("busy", int'(busy_o), 1);
      if (i == 0) begin
        chk("held_idx", int'(result_index_o), exp_idx);
        chk("held_val", int'(result_variable_o), exp_val);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    if (abort_after >= 0) begin
      chk("abort_rv", int'(result_valid_o), 0);
      return;
    end
    ref_model(m, ridx, rval);
    chk("rv", int'(result_valid_o), 1);
    chk("idx", int'(result_index_o), ridx);
    chk("val", int'(result_variable_o), rval);
    exp_idx = ridx; exp_val = rval;
    exp_pulses++;
    pulse_cyc = cyc;
  endtask

  // After DONE: back to idle, stray valid ignored, result held.
  task automatic post_frame();
    @(negedge clk);
    valid_i = 1'b1; variable_i = W'($urandom);
    chk("post_busy", int'(busy_o), 0);
    chk("post_ready", int'(ready_o), 0);
    chk("post_rv", int'(result_valid_o), 0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("post_rv2", int'(result_valid_o), 0);
    chk("post_idx", int'(result_index_o), exp_idx);
    chk("post_val", int'(result_variable_o), exp_val);
  endtask

  task automatic rand_samples(input bit narrow);
    foreach (samp[i])
      samp[i] = narrow ? ($urandom_range(6, 0) - 3) : int'($signed(W'($urandom)));
  endtask

  initial begin
    int c1;
    #1 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    samp = '{30, -7, 12, -7, 100};
    run_frame(1'b0, 0, -1); post_frame();

    samp = '{-32768, -1, 32767, 32767, 0};
    run_frame(1'b1, 0, -1); post_frame();

    samp = '{5, 4, 3, 2, 1};
    run_frame(1'b0, 3, -1); post_frame();

    // Abort a winner frame; the sample alongside the new start must be dropped.
    samp = '{1, 2, 3, 4, 5};
    run_frame(1'b1, 0, 3);
    valid_i = 1'b1; variable_i = -16'sd100;
    samp = '{9, 8, 9, 9, 9};
    run_frame(1'b0, 0, -1); post_frame();

    // Reset mid-frame.
    rand_samples(0);
    run_frame(1'b1, 1, 2);
    reset_n = 1'b0;
    #2 chk_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    exp_idx = 0; exp_val = 0;
    @(negedge clk);
    chk("rst_idx", int'(result_index_o), 0);
    chk("rst_val", int'(result_variable_o), 0);
    rand_samples(0);
    run_frame(1'b0, 1, -1); post_frame();

    // Back-to-back at full rate.
    rand_samples(0);
    run_frame(1'b1, 0, -1);
    c1 = pulse_cyc;
    rand_samples(1);
    run_frame(1'b0, 0, -1);
    chk("b2b_gap", pulse_cyc - c1, N + 1);
    post_frame();

    for (int k = 0; k < 8; k++) begin
      rand_samples(k[0]);
      run_frame(1'($urandom), 2, -1);
      post_frame();
    end

    chk("pulse_count", pulses, exp_pulses);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
